// File: rtl/sram_arbiter_pkg.sv
// Shared types and helpers for the SRAM arbiter between instruction fetch and data ports.
package sram_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Values double as bit positions in the one-hot grant vector.
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

    // Clear the byte offset so the SRAM always sees a word address.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

    // Any non-zero byte offset is a misaligned word access.
    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/sram_arb_priority.sv
// Grant selection between fetch and data requesters. Data normally wins; after
// STARVE_LIMIT consecutive data grants taken while fetch was waiting, fetch is
// forced through once.
module sram_arb_priority
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       grant_en,
    input  logic       if_req,
    input  logic       d_req,
    output logic [1:0] gnt
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_r;
    logic                fetch_forced_s;
    logic [1:0]          gnt_s;

    assign fetch_forced_s = if_req && (streak_r == STREAK_MAX);
    assign gnt            = gnt_s;

    // Pick at most one winner, and only while the arbiter can accept a request.
    always_comb begin
        gnt_s = 2'b00;
        if (!grant_en) begin
            gnt_s = 2'b00;
        end else if (d_req && !fetch_forced_s) begin
            gnt_s[PORT_D] = 1'b1;
        end else if (if_req) begin
            gnt_s[PORT_IF] = 1'b1;
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Count data grants that kept fetch waiting; saturate at the limit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            streak_r <= STREAK_W'(0);
        end else if (gnt_s[PORT_IF]) begin
            streak_r <= STREAK_W'(0);
        end else if (gnt_s[PORT_D]) begin
            if (!if_req) begin
                streak_r <= STREAK_W'(0);
            end else if (streak_r != STREAK_MAX) begin
                streak_r <= streak_r + STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-ported SRAM arbiter: one access at a time for the fetch and data ports,
// with misalignment rejection, an access timeout and per-port responses.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_err,
    output logic              sram_write_enable,
    output logic [WORD_W-1:0] sram_address,
    output logic [WORD_W-1:0] sram_write_data,
    input  logic              sram_hreadyout,
    input  logic [WORD_W-1:0] sram_read_data
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_r;
    state_t            state_s;
    logic              grant_en_s;
    logic [1:0]        gnt_s;
    logic              granted_s;
    port_id_t          owner_s;
    port_id_t          owner_r;
    logic [WORD_W-1:0] addr_s;
    logic [WORD_W-1:0] addr_r;
    logic              we_s;
    logic              we_r;
    logic [WORD_W-1:0] wdata_s;
    logic [WORD_W-1:0] wdata_r;
    logic              misaligned_s;
    logic [TMO_W-1:0]  tmo_r;
    logic              busy_s;
    logic              complete_s;
    logic              abort_s;
    logic              resp_load_s;
    port_id_t          resp_owner_s;
    logic [WORD_W-1:0] resp_rdata_s;
    logic              resp_err_s;
    logic              if_rvalid_r;
    logic [WORD_W-1:0] if_rdata_r;
    logic              if_err_r;
    logic              d_rvalid_r;
    logic [WORD_W-1:0] d_rdata_r;
    logic              d_err_r;

    assign grant_en_s = (state_r == IDLE);

    sram_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .grant_en (grant_en_s),
        .if_req   (if_req),
        .d_req    (d_req),
        .gnt      (gnt_s)
    );

    assign if_gnt       = gnt_s[PORT_IF];
    assign d_gnt        = gnt_s[PORT_D];
    assign granted_s    = |gnt_s;
    assign misaligned_s = is_misaligned(addr_s);
    assign busy_s       = (state_r == BUSY);
    assign complete_s   = busy_s && sram_hreadyout;
    assign abort_s      = busy_s && !sram_hreadyout && (tmo_r == TMO_LAST);

    // Route the winning requester's command; fetch is always a read.
    always_comb begin
        owner_s = PORT_IF;
        addr_s  = if_addr;
        we_s    = 1'b0;
        wdata_s = {WORD_W{1'b0}};
        if (gnt_s[PORT_D]) begin
            owner_s = PORT_D;
            addr_s  = d_addr;
            we_s    = d_we;
            wdata_s = d_wdata;
        end else begin
            owner_s = PORT_IF;
            addr_s  = if_addr;
            we_s    = 1'b0;
            wdata_s = {WORD_W{1'b0}};
        end
    end

    // Capture the accepted command so the SRAM side stays stable through BUSY.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_r <= PORT_IF;
            addr_r  <= {WORD_W{1'b0}};
            we_r    <= 1'b0;
            wdata_r <= {WORD_W{1'b0}};
        end else if (granted_s) begin
            owner_r <= owner_s;
            addr_r  <= word_align(addr_s);
            we_r    <= we_s;
            wdata_r <= wdata_s;
        end
    end

    // Access state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: misaligned requests skip the SRAM; BUSY ends on ready or timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (granted_s) begin
                    state_s = misaligned_s ? RESP : BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (complete_s || abort_s) begin
                    state_s = RESP;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Count BUSY cycles spent waiting for the SRAM; cleared whenever the wait ends.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_r <= TMO_W'(0);
        end else if (busy_s && !sram_hreadyout && !abort_s) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end else begin
            tmo_r <= TMO_W'(0);
        end
    end

    // Work out what the response will carry as the FSM enters RESP.
    always_comb begin
        resp_load_s  = (state_s == RESP) && (state_r != RESP);
        resp_owner_s = owner_r;
        resp_err_s   = 1'b0;
        resp_rdata_s = {WORD_W{1'b0}};
        if (state_r == IDLE) begin
            // Only a misaligned grant jumps from IDLE straight to RESP.
            resp_owner_s = owner_s;
            resp_err_s   = 1'b1;
        end else if (abort_s) begin
            resp_err_s   = 1'b1;
        end else if (complete_s && !we_r) begin
            resp_rdata_s = sram_read_data;
        end else begin
            resp_rdata_s = {WORD_W{1'b0}};
        end
    end

    // One-cycle response to the owning port only; the other port stays quiet.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            if_rvalid_r <= 1'b0;
            if_rdata_r  <= {WORD_W{1'b0}};
            if_err_r    <= 1'b0;
            d_rvalid_r  <= 1'b0;
            d_rdata_r   <= {WORD_W{1'b0}};
            d_err_r     <= 1'b0;
        end else if (resp_load_s && (resp_owner_s == PORT_D)) begin
            if_rvalid_r <= 1'b0;
            if_rdata_r  <= {WORD_W{1'b0}};
            if_err_r    <= 1'b0;
            d_rvalid_r  <= 1'b1;
            d_rdata_r   <= resp_rdata_s;
            d_err_r     <= resp_err_s;
        end else if (resp_load_s) begin
            if_rvalid_r <= 1'b1;
            if_rdata_r  <= resp_rdata_s;
            if_err_r    <= resp_err_s;
            d_rvalid_r  <= 1'b0;
            d_rdata_r   <= {WORD_W{1'b0}};
            d_err_r     <= 1'b0;
        end else begin
            if_rvalid_r <= 1'b0;
            if_rdata_r  <= {WORD_W{1'b0}};
            if_err_r    <= 1'b0;
            d_rvalid_r  <= 1'b0;
            d_rdata_r   <= {WORD_W{1'b0}};
            d_err_r     <= 1'b0;
        end
    end

    assign if_rvalid = if_rvalid_r;
    assign if_rdata  = if_rdata_r;
    assign if_err    = if_err_r;
    assign d_rvalid  = d_rvalid_r;
    assign d_rdata   = d_rdata_r;
    assign d_err     = d_err_r;

    // SRAM side is driven only during BUSY, so a write strobe can never leak out.
    always_comb begin
        sram_write_enable = 1'b0;
        sram_address      = {WORD_W{1'b0}};
        sram_write_data   = {WORD_W{1'b0}};
        if (busy_s) begin
            sram_write_enable = we_r;
            sram_address      = addr_r;
            sram_write_data   = wdata_r;
        end else begin
            sram_write_enable = 1'b0;
            sram_address      = {WORD_W{1'b0}};
            sram_write_data   = {WORD_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a vector table of single accesses, a
// contention sequence and a reset-during-access sequence, with a response scoreboard.
module tb_sram_arbiter;

    localparam int TIMEOUT = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        sram_write_enable;
    logic [31:0] sram_address, sram_write_data;
    logic        sram_hreadyout = 1'b0;
    logic [31:0] sram_read_data = 32'h0;

    always #5 HCLK = ~HCLK;

    sram_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .sram_write_enable(sram_write_enable), .sram_address(sram_address),
        .sram_write_data(sram_write_data), .sram_hreadyout(sram_hreadyout),
        .sram_read_data(sram_read_data)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    typedef struct {
        string       name;
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_in;
        int          delay;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   rv_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge HCLK) begin
        if (HRESETn && (if_rvalid || d_rvalid)) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {if_rvalid, d_rvalid}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                chk("response", {if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err},
                    mon_e.is_d ? {1'b0, 32'h0, 1'b0, 1'b1, mon_e.rdata, mon_e.err}
                               : {1'b1, mon_e.rdata, mon_e.err, 1'b0, 32'h0, 1'b0});
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge HCLK);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // One complete access: request, grant, BUSY cycles with SRAM checks, response timing.
    task automatic run_access(input vec_t v);
        int   n;
        int   k;
        bit   done;
        bit   mis;
        bit   g;
        exp_t e;
        mis = (v.addr[1:0] != 2'b00);
        @(negedge HCLK);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        sram_hreadyout = 1'b0;
        sram_read_data = v.rd_in;
        #1;
        n = 0;
        g = v.is_d ? d_gnt : if_gnt;
        while (!g && n < 20) begin
            @(negedge HCLK);
            #1;
            n++;
            g = v.is_d ? d_gnt : if_gnt;
        end
        chk({v.name, "_gnt"}, g, 1'b1);
        if (!g) begin
            d_req = 1'b0; if_req = 1'b0;
            return;
        end
        chk({v.name, "_we_idle"}, sram_write_enable, 1'b0);
        e.is_d = v.is_d; e.rdata = v.exp_rdata; e.err = v.exp_err;
        exp_q.push_back(e);
        @(negedge HCLK);
        d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
        if (!mis) begin
            k = 0;
            done = 1'b0;
            while (!done) begin
                sram_hreadyout = (k == v.delay);
                #1;
                chk({v.name, "_addr"}, sram_address, {v.addr[31:2], 2'b00});
                chk({v.name, "_we_busy"}, sram_write_enable, v.is_d & v.we);
                if (v.is_d && v.we) chk({v.name, "_wdata"}, sram_write_data, v.wdata);
                if (k == v.delay || k == TIMEOUT - 1) done = 1'b1;
                k++;
                @(negedge HCLK);
                sram_hreadyout = 1'b0;
            end
        end
        chk({v.name, "_rvalid_time"}, v.is_d ? d_rvalid : if_rvalid, 1'b1);
        chk({v.name, "_we_resp"}, sram_write_enable, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   ng;
        int   cyc;
        int   rv_before;
        logic [5:0] order;

        vecs[0] = '{"load",        1'b1, 1'b0, 32'h0000_0040, 32'h0,          32'hDEAD_BEEF,  2, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{"store",       1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678,  32'h9999_9999,  0, 32'h0,         1'b0};
        vecs[2] = '{"fetch0",      1'b0, 1'b0, 32'h0000_0080, 32'h0,          32'hCAFE_F00D,  0, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{"fetch3",      1'b0, 1'b0, 32'h0000_0084, 32'h0,          32'h0000_1111,  3, 32'h0000_1111, 1'b0};
        vecs[4] = '{"d_misalign",  1'b1, 1'b0, 32'h0000_0042, 32'h0,          32'h7777_7777,  0, 32'h0,         1'b1};
        vecs[5] = '{"if_misalign", 1'b0, 1'b0, 32'h0000_1001, 32'h0,          32'h7777_7777,  0, 32'h0,         1'b1};
        vecs[6] = '{"load_tmo",    1'b1, 1'b0, 32'h0000_0048, 32'h0,          32'h5555_5555, 99, 32'h0,         1'b1};
        vecs[7] = '{"store_tmo",   1'b1, 1'b1, 32'h0000_004C, 32'hAAAA_0001,  32'h5555_5555, 99, 32'h0,         1'b1};
        vecs[8] = '{"load_top",    1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'h8000_0001,  1, 32'h8000_0001, 1'b0};
        vecs[9] = '{"fetch_last",  1'b0, 1'b0, 32'h0000_0000, 32'h0,          32'h1357_2468, 15, 32'h1357_2468, 1'b0};

        // Reset state
        #2;
        chk("rst_hold_sram", {sram_write_enable, sram_address, sram_write_data}, 65'h0);
        #8;
        HRESETn = 1'b1;
        @(negedge HCLK);
        #1;
        chk("rst_resp_out", {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err}, 70'h0);
        chk("rst_sram_out", {sram_write_enable, sram_address, sram_write_data}, 65'h0);

        // Table of single accesses
        for (int i = 0; i < 10; i++) begin
            run_access(vecs[i]);
        end
        wait_drain("table_drain");

        // Contention: both ports request continuously
        @(negedge HCLK);
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        sram_hreadyout = 1'b1; sram_read_data = 32'hA5A5_0000;
        ng = 0; cyc = 0; order = 6'b0;
        while (ng < 6 && cyc < 100) begin
            #1;
            if (if_gnt || d_gnt) begin
                chk("one_hot_gnt", if_gnt & d_gnt, 1'b0);
                order = {order[4:0], d_gnt};
                mon_e.is_d = d_gnt; mon_e.rdata = 32'hA5A5_0000; mon_e.err = 1'b0;
                exp_q.push_back(mon_e);
                ng++;
            end
            @(negedge HCLK);
            cyc++;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("grant_order", order, 6'b111101);
        wait_drain("contention_drain");
        sram_hreadyout = 1'b0;

        // Reset in the middle of a store
        @(negedge HCLK);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0060; d_wdata = 32'hFFFF_0000;
        #1;
        chk("rst_mid_gnt", d_gnt, 1'b1);
        @(negedge HCLK);
        d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("rst_mid_busy_we", sram_write_enable, 1'b1);
        rv_before = rv_cnt;
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_sram", {sram_write_enable, sram_address, sram_write_data}, 65'h0);
        chk("rst_mid_resp", {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err}, 70'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        sram_hreadyout = 1'b1;
        repeat (20) @(negedge HCLK);
        sram_hreadyout = 1'b0;
        chk("rst_mid_no_rvalid", rv_cnt - rv_before, 0);

        // Requester reissues after reset
        run_access('{"post_reset", 1'b1, 1'b0, 32'h0000_0060, 32'h0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0});
        wait_drain("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
